viterbi_link_ctrl: RTL

//  Frame sequencer for the encoder -> channel -> Viterbi decoder link. Pulls

---
 rtl/viterbi_link_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/viterbi_link_ctrl.sv
// viterbi_link_ctrl: frame sequencer and bit-error scoreboard for an encoder/channel/Viterbi link.
// Burst error injection into the channel is built only when VITERBI_ERR_INJ_EN is defined.
module viterbi_link_ctrl #(
  parameter int FRAME_LEN  = 64,
  parameter int TAIL_LEN   = 2,
  parameter int DEC_LAT    = 16,
  parameter int MAX_FRAMES = 4
`ifdef VITERBI_ERR_INJ_EN
  ,
  parameter int ERR_PERIOD = 32,
  parameter int ERR_BURST  = 4
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        src_valid_i,
  input  logic        src_bit_i,
  output logic        src_ready_o,
  output logic        enc_enable_o,
  output logic        enc_bit_o,
  output logic [1:0]  err_inj_o,
  input  logic        dec_bit_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] frame_ct_o,
  output logic [15:0] bit_err_ct_o,
  output logic [15:0] chan_err_ct_o
);
  localparam int CMAX = (FRAME_LEN > TAIL_LEN) ? ((FRAME_LEN > DEC_LAT) ? FRAME_LEN : DEC_LAT)
                                               : ((TAIL_LEN > DEC_LAT) ? TAIL_LEN : DEC_LAT);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PAY_LAST   = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] TAIL_LAST  = CW'(TAIL_LEN - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DEC_LAT - 1);
  localparam logic [15:0]   MAXF       = 16'(MAX_FRAMES);

  typedef enum logic [2:0] {IDLE, PAYLOAD, TAIL, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [15:0]          frame_q, frame_d;
  logic [15:0]          bit_err_q;
  logic [DEC_LAT-1:0]   sb_en_q, sb_bit_q;
  logic                 launch;

  assign launch = start_i && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = PAYLOAD;
        cnt_d   = '0;
        frame_d = '0;
      end
      PAYLOAD: if (src_valid_i) begin
        cnt_d   = (cnt_q == PAY_LAST) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == PAY_LAST) ? TAIL : PAYLOAD;
      end
      TAIL: begin
        cnt_d   = (cnt_q == TAIL_LAST) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == TAIL_LAST) ? DRAIN : TAIL;
      end
      DRAIN: if (cnt_q == DRAIN_LAST) begin
        cnt_d   = '0;
        frame_d = frame_q + 16'd1;
        state_d = (frame_q + 16'd1 < MAXF) ? PAYLOAD : DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_ready_o  = state_q == PAYLOAD;
    enc_enable_o = (state_q == PAYLOAD) ? src_valid_i : (state_q == TAIL);
    enc_bit_o    = (state_q == PAYLOAD) && src_bit_i;
    busy_o       = state_q == PAYLOAD || state_q == TAIL || state_q == DRAIN;
    done_o       = state_q == DONE;
  end

  // The tap is the {enable,bit} launched DEC_LAT clocks ago; stalls arrive with enable=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_en_q   <= '0;
      sb_bit_q  <= '0;
      bit_err_q <= '0;
    end else begin
      sb_en_q  <= {sb_en_q[DEC_LAT-2:0], enc_enable_o};
      sb_bit_q <= {sb_bit_q[DEC_LAT-2:0], enc_bit_o};
      if (launch)
        bit_err_q <= '0;
      else if (sb_en_q[DEC_LAT-1] && sb_bit_q[DEC_LAT-1] != dec_bit_i && bit_err_q != 16'hFFFF)
        bit_err_q <= bit_err_q + 16'd1;
    end
  end

  assign frame_ct_o   = frame_q;
  assign bit_err_ct_o = bit_err_q;

`ifdef VITERBI_ERR_INJ_EN
  localparam int SW = $clog2(ERR_PERIOD + 1);
  localparam logic [SW-1:0] SYM_LAST = SW'(ERR_PERIOD - 1);
  localparam logic [SW-1:0] SYM_TH   = SW'(ERR_PERIOD - ERR_BURST);

  logic [SW-1:0] sym_q, sym_d;
  logic [1:0]    inj_q;
  logic [15:0]   chan_q;
  logic          hit;

  assign hit   = enc_enable_o && sym_q >= SYM_TH;
  assign sym_d = (state_d == PAYLOAD && state_q != PAYLOAD) ? '0 :
                 enc_enable_o ? ((sym_q == SYM_LAST) ? '0 : sym_q + 1'b1) : sym_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_q  <= '0;
      inj_q  <= '0;
      chan_q <= '0;
    end else begin
      sym_q  <= sym_d;
      inj_q  <= hit ? 2'b11 : 2'b00;
      chan_q <= launch ? '0 : hit ? ((chan_q >= 16'hFFFD) ? 16'hFFFF : chan_q + 16'd2) : chan_q;
    end
  end

  assign err_inj_o     = inj_q;
  assign chan_err_ct_o = chan_q;
`else
  assign err_inj_o     = 2'b00;
  assign chan_err_ct_o = 16'h0000;
`endif
endmodule
